des_cbc_ctrl: RTL and testbench
===============================

// Module: des_cbc_ctrl
// PURPOSE
//  Sequential mode controller upstream of the combinational DES core (ports enc1_dec0, in, key, out).
//  Accepts 64-bit blocks over a valid/ready stream and drives the core's in/key/enc1_dec0 from registers.
//  Waits DES_WAIT cycles for the core output to settle (multicycle path), applies ECB or CBC chaining,
//  and returns results over a valid/ready stream. Bit 1 is the MSB of every 64-bit bus ([1:64]).
// PARAMETERS
//  DES_WAIT  2  clock cycles from driving des_in until des_out is sampled; legal range 1..15
// PORTS
//  clk            in   1   clock; all state updates on the rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  cfg_valid      in   1   load key/IV/mode; honoured only in IDLE
//  cfg_key        in   64  DES key; parity bits are passed through unchanged
//  cfg_iv         in   64  CBC initial vector; loaded into the chain register
//  cfg_enc1_dec0  in   1   1 = encrypt, 0 = decrypt
//  cfg_cbc1_ecb0  in   1   1 = CBC, 0 = ECB
//  in_valid       in   1   input block valid
//  in_ready       out  1   input block accepted when in_valid && in_ready
//  in_data        in   64  plaintext (enc) or ciphertext (dec)
//  out_valid      out  1   result valid; held until out_ready
//  out_ready      in   1   downstream accepts the result
//  out_data       out  64  result block; stable while out_valid && !out_ready
//  busy           out  1   high in CALC or OUT
//  des_enc1_dec0  out  1   to core enc1_dec0 (registered mode)
//  des_in         out  64  to core in (registered)
//  des_key        out  64  to core key (registered)
//  des_out        in   64  from core out
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 while rst_n=0; out_valid=0; out_data=0; busy=0; des_in=0; des_key=0;
//   des_enc1_dec0=1; chain=0; mode=ECB encrypt; wait counter=0. Reset mid-block discards the block.
//  FSM IDLE: in_ready = !cfg_valid (combinational). cfg_valid loads key, iv->chain, mode; this takes
//   priority over in_valid in the same cycle (no input accepted). On an input handshake, capture
//   blk=in_data; des_in <= (CBC && enc) ? in_data ^ chain : in_data; counter <= DES_WAIT-1; go to CALC.
//  CALC: in_ready=0; decrement counter; when counter==0, capture res=des_out, go to OUT.
//   CBC enc: out_data=res. CBC dec: out_data=res ^ chain. ECB: out_data=res.
//  OUT: out_valid=1; out_data held. On out_ready, chain update: CBC enc -> chain<=res;
//   CBC dec -> chain<=blk; ECB -> chain unchanged. Go to IDLE the same edge.
//  Latency: an input accepted at edge T yields out_valid high after edge T+DES_WAIT.
//   Throughput is one block per DES_WAIT+2 cycles when out_ready is held high.
//  cfg_valid while busy is ignored (no state change); the key and mode are constant for a block in flight.
//  des_key/des_enc1_dec0 change only on a cfg load; des_in changes only on an input handshake.
//  in_data/in_valid changes while in_ready=0 have no effect. All XORs are full 64-bit; no carries.
// TESTING
//  ECB enc: key 133457799BBCDFF1, in 0123456789ABCDEF -> out_data 85E813540F0AB405, out_valid at T+DES_WAIT.
//  ECB dec: same key, in 85E813540F0AB405 -> out 0123456789ABCDEF.
//  CBC enc: IV FFFFFFFFFFFFFFFF, in FEDCBA9876543210 -> out 85E813540F0AB405; chain then = 85E8...05.
//  CBC dec: IV FFFFFFFFFFFFFFFF, in 85E813540F0AB405 -> out FEDCBA9876543210; a 3-block round trip
//   with CBC enc then CBC dec reproduces the plaintext exactly.
//  Backpressure: out_ready low 5 cycles -> out_valid and out_data stable, in_ready=0, chain unchanged.
//  cfg_valid+in_valid in the same IDLE cycle -> cfg loaded, no input accepted; rst_n pulse in CALC -> IDLE, out_valid=0.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// ECB/CBC mode controller wrapped around a combinational DES core.
// Registers the core inputs, waits DES_WAIT cycles for settling, applies chaining, streams results out.
module des_cbc_ctrl #(
    parameter int unsigned DES_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    input  logic [1:64] cfg_key,
    input  logic [1:64] cfg_iv,
    input  logic        cfg_enc1_dec0,
    input  logic        cfg_cbc1_ecb0,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:64] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] out_data,
    output logic        busy,
    output logic        des_enc1_dec0,
    output logic [1:64] des_in,
    output logic [1:64] des_key,
    input  logic [1:64] des_out
);

    localparam int unsigned BLK_W = 64;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:BLK_W]   chain_q, chain_d;
    logic [1:BLK_W]   blk_q, blk_d;
    logic [1:BLK_W]   key_q, key_d;
    logic [1:BLK_W]   des_in_q, des_in_d;
    logic [1:BLK_W]   out_data_q, out_data_d;
    logic             enc_q, enc_d;
    logic             cbc_q, cbc_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    // Config has priority over data in IDLE; held low while reset is asserted.
    assign in_ready = rst_n && (state_q == IDLE) && !cfg_valid;

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign des_enc1_dec0 = enc_q;
    assign des_in        = des_in_q;
    assign des_key       = key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            chain_q     <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            des_in_q    <= '0;
            out_data_q  <= '0;
            enc_q       <= 1'b1;
            cbc_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chain_q     <= chain_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            des_in_q    <= des_in_d;
            out_data_q  <= out_data_d;
            enc_q       <= enc_d;
            cbc_q       <= cbc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        blk_d       = blk_q;
        key_d       = key_q;
        des_in_d    = des_in_q;
        out_data_d  = out_data_q;
        enc_d       = enc_q;
        cbc_d       = cbc_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    key_d   = cfg_key;
                    chain_d = cfg_iv;
                    enc_d   = cfg_enc1_dec0;
                    cbc_d   = cfg_cbc1_ecb0;
                end else if (in_valid) begin
                    blk_d    = in_data;
                    des_in_d = (cbc_q && enc_q) ? (in_data ^ chain_q) : in_data;
                    cnt_d    = CNT_W'(DES_WAIT - 1);
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Core output is sampled only once the multicycle window has elapsed.
                if (cnt_q == '0) begin
                    out_data_d  = (cbc_q && !enc_q) ? (des_out ^ chain_q) : des_out;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (cbc_q) begin
                        chain_d = enc_q ? out_data_q : blk_q;
                    end
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Self-checking bench for des_cbc_ctrl with a stand-in combinational core that honours
// the reference DES pair and is otherwise a keyed bijection with a matching inverse.
module tb_des_cbc_ctrl;

    localparam int unsigned DES_WAIT = 2;
    localparam logic [63:0] KV  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] MASK = 64'hA5C30F965A3CF069;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [1:64] cfg_key;
    logic [1:64] cfg_iv;
    logic        cfg_enc1_dec0;
    logic        cfg_cbc1_ecb0;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_data;
    logic        busy;
    logic        des_enc1_dec0;
    logic [1:64] des_in;
    logic [1:64] des_key;
    logic [1:64] des_out;

    int n_chk  = 0;
    int n_fail = 0;

    des_cbc_ctrl #(.DES_WAIT(DES_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_enc1_dec0(cfg_enc1_dec0), .cfg_cbc1_ecb0(cfg_cbc1_ecb0),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .des_enc1_dec0(des_enc1_dec0), .des_in(des_in),
        .des_key(des_key), .des_out(des_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] toy_e(input logic [63:0] x, input logic [63:0] k);
        logic [63:0] t;
        t = x ^ k;
        return {t[50:0], t[63:51]} ^ MASK;
    endfunction

    function automatic logic [63:0] toy_d(input logic [63:0] y, input logic [63:0] k);
        logic [63:0] t;
        t = y ^ MASK;
        return {t[12:0], t[63:13]} ^ k;
    endfunction

    // PT<->CT swapped into the toy permutation under KV so the reference vector holds.
    function automatic logic [63:0] core_e(input logic [63:0] x, input logic [63:0] k);
        if (k == KV && x == PT) return CT;
        if (k == KV && x == toy_d(CT, k)) return toy_e(PT, k);
        return toy_e(x, k);
    endfunction

    function automatic logic [63:0] core_d(input logic [63:0] y, input logic [63:0] k);
        if (k == KV && y == CT) return PT;
        if (k == KV && y == toy_e(PT, k)) return toy_d(CT, k);
        return toy_d(y, k);
    endfunction

    always_comb des_out = des_enc1_dec0 ? core_e(des_in, des_key) : core_d(des_in, des_key);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [63:0] k, input logic [63:0] iv, input logic enc, input logic cbc);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = k; cfg_iv = iv;
        cfg_enc1_dec0 = enc; cfg_cbc1_ecb0 = cbc;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Push one block, check latency and stall stability, return the result and the core input seen.
    task automatic send_block(input logic [63:0] din, input int stall, input bit noise,
                              output logic [63:0] got, output logic [63:0] core_in);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_data = din;
        #1 chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {$urandom, $urandom};
        core_in = des_in;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(DES_WAIT));
        chk("busy_out", 64'(busy), 64'd1);
        got = out_data;
        for (int s = 0; s < stall; s++) begin
            if (noise) begin
                cfg_valid = 1'b1; cfg_key = {$urandom, $urandom}; cfg_iv = {$urandom, $urandom};
                cfg_enc1_dec0 = 1'($urandom); cfg_cbc1_ecb0 = 1'($urandom);
                in_valid = 1'($urandom); in_data = {$urandom, $urandom};
            end
            @(posedge clk); #1;
            chk("stall_stable", {62'd0, out_valid, in_ready}, 64'd2);
            chk("stall_data", out_data, got);
        end
        @(negedge clk);
        cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_done", {62'd0, out_valid, busy}, 64'd0);
    endtask

    typedef struct {
        bit          cfg;
        logic [63:0] key;
        logic [63:0] iv;
        logic        enc;
        logic        cbc;
        logic [63:0] din;
        logic [63:0] exp_out;
        logic [63:0] exp_core_in;
        int          stall;
    } vec_t;

    vec_t vt[6];

    logic [63:0] m_key, m_chain, got, cin, exp_out, exp_cin, saved, iv_rt;
    logic        m_enc, m_cbc;
    logic [63:0] pts[3];
    logic [63:0] cts[3];

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_key = '0; cfg_iv = '0;
        cfg_enc1_dec0 = 1'b0; cfg_cbc1_ecb0 = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vt[0] = '{1'b1, KV, 64'd0, 1'b1, 1'b0, PT, CT, PT, 0};
        vt[1] = '{1'b1, KV, 64'd0, 1'b0, 1'b0, CT, PT, CT, 2};
        vt[2] = '{1'b1, KV, ONES, 1'b1, 1'b1, 64'hFEDCBA9876543210, CT, PT, 5};
        vt[3] = '{1'b0, KV, ONES, 1'b1, 1'b1, 64'h84CB563386A179EA, CT, PT, 0};
        vt[4] = '{1'b1, KV, ONES, 1'b0, 1'b1, CT, 64'hFEDCBA9876543210, CT, 1};
        vt[5] = '{1'b0, KV, ONES, 1'b0, 1'b1, CT, 64'h84CB563386A179EA, CT, 0};

        // Reset values
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_outs", {60'd0, out_valid, busy, des_enc1_dec0, 1'b0}, 64'd2);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_des_in", des_in, 64'd0);
        chk("rst_des_key", des_key, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Reference vectors
        for (int i = 0; i < 6; i++) begin
            if (vt[i].cfg) do_cfg(vt[i].key, vt[i].iv, vt[i].enc, vt[i].cbc);
            send_block(vt[i].din, vt[i].stall, 1'b0, got, cin);
            chk($sformatf("vec%0d_out", i), got, vt[i].exp_out);
            chk($sformatf("vec%0d_core_in", i), cin, vt[i].exp_core_in);
            chk($sformatf("vec%0d_key", i), des_key, vt[i].key);
            chk($sformatf("vec%0d_mode", i), 64'(des_enc1_dec0), 64'(vt[i].enc));
        end

        // cfg_valid and in_valid together: config wins, nothing accepted
        saved = des_in;
        m_key = {$urandom, $urandom};
        @(negedge clk);
        cfg_valid = 1'b1; cfg_key = m_key; cfg_iv = '0; cfg_enc1_dec0 = 1'b0; cfg_cbc1_ecb0 = 1'b0;
        in_valid = 1'b1; in_data = {$urandom, $urandom};
        #1 chk("cfg_prio_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("cfg_prio_busy", 64'(busy), 64'd0);
        chk("cfg_prio_key", des_key, m_key);
        chk("cfg_prio_mode", 64'(des_enc1_dec0), 64'd0);
        chk("cfg_prio_des_in", des_in, saved);
        @(negedge clk); cfg_valid = 1'b0; in_valid = 1'b0;

        // Three-block CBC round trip
        m_key = {$urandom, $urandom};
        iv_rt = {$urandom, $urandom};
        do_cfg(m_key, iv_rt, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            pts[i] = {$urandom, $urandom};
            send_block(pts[i], i, 1'b1, got, cin);
            cts[i] = got;
        end
        do_cfg(m_key, iv_rt, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_block(cts[i], 0, 1'b0, got, cin);
            chk($sformatf("roundtrip%0d", i), got, pts[i]);
        end

        // Randomized blocks against the transaction-level CBC/ECB model
        m_key = '0; m_chain = '0; m_enc = 1'b1; m_cbc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [63:0] din;
            if (i % 8 == 0 || $urandom_range(4) == 0) begin
                m_key   = ($urandom_range(2) == 0) ? KV : {$urandom, $urandom};
                m_chain = {$urandom, $urandom};
                m_enc   = 1'($urandom);
                m_cbc   = 1'($urandom);
                do_cfg(m_key, m_chain, m_enc, m_cbc);
            end
            case ($urandom_range(5))
                0: din = PT;
                1: din = CT;
                default: din = {$urandom, $urandom};
            endcase
            if (m_enc) begin
                exp_cin = m_cbc ? (din ^ m_chain) : din;
                exp_out = core_e(exp_cin, m_key);
                if (m_cbc) m_chain = exp_out;
            end else begin
                exp_cin = din;
                exp_out = m_cbc ? (core_d(din, m_key) ^ m_chain) : core_d(din, m_key);
                if (m_cbc) m_chain = din;
            end
            send_block(din, $urandom_range(3), 1'b1, got, cin);
            chk($sformatf("rnd%0d_out", i), got, exp_out);
            chk($sformatf("rnd%0d_core_in", i), cin, exp_cin);
            chk($sformatf("rnd%0d_key", i), des_key, m_key);
        end

        // Reset pulse while a block is in CALC discards it
        do_cfg(KV, 64'd0, 1'b1, 1'b0);
        @(negedge clk); in_valid = 1'b1; in_data = PT;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("calc_busy", 64'(busy), 64'd1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("calc_rst_outs", {61'd0, out_valid, busy, in_ready}, 64'd0);
        chk("calc_rst_key", des_key, 64'd0);
        chk("calc_rst_mode", 64'(des_enc1_dec0), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (DES_WAIT + 4) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("calc_rst_no_out", 64'(seen), 64'd0);
        end
        chk("calc_rst_idle", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
